// File: rtl/riscv_core_pkg.sv
// Shared types for the ALU issue stage: op_code map, RV32I opcodes,
// branch funct3 codes and the decoded-instruction record.
package riscv_core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_TEST = 4'd15
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'd0,
    F3_BNE  = 3'd1,
    F3_BLT  = 3'd4,
    F3_BGE  = 3'd5,
    F3_BLTU = 3'd6,
    F3_BGEU = 3'd7
  } br_f3_e;

  // Result class: how S2 turns the ALU return into writeback/branch info.
  // Signed and unsigned compares share a class because both resolve on out[0].
  typedef enum logic [2:0] {
    CLS_WB  = 3'd0,
    CLS_BEQ = 3'd1,
    CLS_BNE = 3'd2,
    CLS_BLT = 3'd3,
    CLS_BGE = 3'd4,
    CLS_ILL = 3'd5
  } cls_e;

  typedef struct packed {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    cls_e        cls;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        illegal;
  } decoded_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wb_en;
    logic        br_taken;
    logic [31:0] br_target;
    logic        illegal;
  } out_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder: instruction + operands -> ALU request record.
module instr_decoder
  import riscv_core_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output decoded_t    dec
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] i_imm;
  logic [31:0] u_imm;
  logic [31:0] b_imm;
  logic        is_imm;
  logic        f7_ok;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign i_imm  = {{20{instr[31]}}, instr[31:20]};
  assign u_imm  = {instr[31:12], 12'b0};
  assign b_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign is_imm = (opcode == OPC_OP_IMM);

  // funct7 legality: shifts and ADD/SUB allow the alternate encoding, SLL(I) does not,
  // the remaining register ops need funct7 == 0 and the remaining immediates are free.
  always_comb begin
    if (funct3 == 3'd1)
      f7_ok = (funct7 == 7'h00);
    else if (funct3 == 3'd5 || (!is_imm && funct3 == 3'd0))
      f7_ok = (funct7 == 7'h00) || (funct7 == 7'h20);
    else
      f7_ok = is_imm || (funct7 == 7'h00);
  end

  // Decode one instruction; anything unrecognised collapses to an illegal ADD 0,0.
  always_comb begin
    // NOTE: every field gets a default first so no path through the case leaves a latch.
    dec         = '0;
    dec.op      = ALU_ADD;
    dec.cls     = CLS_ILL;
    dec.illegal = 1'b1;
    dec.pc      = pc;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        dec.a       = rs1;
        dec.b       = is_imm ? i_imm : rs2;
        dec.imm     = i_imm;
        dec.rd      = instr[11:7];
        dec.cls     = CLS_WB;
        dec.illegal = !f7_ok;
        case (funct3)
          3'd0:    dec.op = (!is_imm && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'd1:    dec.op = ALU_SLL;
          3'd2:    dec.op = ALU_SLT;
          3'd3:    dec.op = ALU_SLTU;
          3'd4:    dec.op = ALU_XOR;
          3'd5:    dec.op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'd6:    dec.op = ALU_OR;
          default: dec.op = ALU_AND;
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.a       = (opcode == OPC_AUIPC) ? pc : '0;
        dec.b       = u_imm;
        dec.imm     = u_imm;
        dec.rd      = instr[11:7];
        dec.cls     = CLS_WB;
        dec.illegal = 1'b0;
      end
      OPC_BRANCH: begin
        dec.a       = rs1;
        dec.b       = rs2;
        dec.imm     = b_imm;
        dec.illegal = 1'b0;
        case (funct3)
          F3_BEQ:  begin dec.op = ALU_SUB;  dec.cls = CLS_BEQ; end
          F3_BNE:  begin dec.op = ALU_SUB;  dec.cls = CLS_BNE; end
          F3_BLT:  begin dec.op = ALU_SLT;  dec.cls = CLS_BLT; end
          F3_BGE:  begin dec.op = ALU_SLT;  dec.cls = CLS_BGE; end
          F3_BLTU: begin dec.op = ALU_SLTU; dec.cls = CLS_BLT; end
          F3_BGEU: begin dec.op = ALU_SLTU; dec.cls = CLS_BGE; end
          default: dec.illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
    if (dec.illegal) begin
      dec.op  = ALU_ADD;
      dec.a   = '0;
      dec.b   = '0;
      dec.rd  = '0;
      dec.imm = '0;
      dec.cls = CLS_ILL;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage ALU issue: S1 holds the decoded request driven to the external ALU,
// S2 registers the ALU return as a writeback/branch result behind valid/ready.
module alu_issue_stage
  import riscv_core_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter bit CHECK_ALU_ERR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero,
  input  logic            alu_sign,
  input  logic [7:0]      alu_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            out_br_taken,
  output logic [XLEN-1:0] out_br_target,
  output logic            out_illegal
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("alu_issue_stage supports XLEN=32 only");
  end

  decoded_t in_dec;
  decoded_t s1_d, s1_q;
  out_t     s2_d, s2_q, s1_res;
  logic     s1_valid_d, s1_valid_q;
  logic     s2_valid_d, s2_valid_q;
  logic     s1_adv, accept, alu_fault, ill, taken_raw, is_branch;
  logic     unused_alu_sign;

  assign unused_alu_sign = alu_sign;

  instr_decoder u_decoder (
    .instr (in_instr),
    .pc    (in_pc),
    .rs1   (in_rs1),
    .rs2   (in_rs2),
    .dec   (in_dec)
  );

  // Handshake: S1 moves on when S2 is empty or draining; flush blocks intake.
  always_comb begin
    s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    in_ready = !flush && (!s1_valid_q || s1_adv);
    accept   = in_valid && in_ready;
  end

  // Resolve the S1 entry against the ALU return; ALU faults poison the result.
  always_comb begin
    alu_fault = CHECK_ALU_ERR && (alu_err != 8'h00);
    ill       = s1_q.illegal || alu_fault;
    is_branch = (s1_q.cls == CLS_BEQ) || (s1_q.cls == CLS_BNE) ||
                (s1_q.cls == CLS_BLT) || (s1_q.cls == CLS_BGE);
    case (s1_q.cls)
      CLS_BEQ: taken_raw = alu_zero;
      CLS_BNE: taken_raw = !alu_zero;
      CLS_BLT: taken_raw = alu_out[0];
      CLS_BGE: taken_raw = !alu_out[0];
      default: taken_raw = 1'b0;
    endcase
    s1_res.result    = alu_out;
    s1_res.rd        = s1_q.rd;
    // A faulted result must not reach the register file or redirect fetch.
    s1_res.wb_en     = (s1_q.cls == CLS_WB) && (s1_q.rd != 5'd0) && !ill;
    s1_res.br_taken  = taken_raw && !ill;
    s1_res.br_target = is_branch ? (s1_q.pc + s1_q.imm) : '0;
    s1_res.illegal   = ill;
  end

  // Next-state for both stages; flush empties the pipe but leaves data as-is.
  always_comb begin
    s1_d       = accept ? in_dec : s1_q;
    s2_d       = s1_adv ? s1_res : s2_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_adv)         s2_valid_d = 1'b1;
      else if (out_ready) s2_valid_d = 1'b0;
      if (accept)         s1_valid_d = 1'b1;
      else if (s1_adv)    s1_valid_d = 1'b0;
    end
  end

  // Stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data registers are reset too, because the ALU operands and out_* are
      // visible at the ports and must read as zero straight out of reset.
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign alu_a         = s1_q.a;
  assign alu_b         = s1_q.b;
  assign alu_op        = s1_q.op;
  assign out_valid     = s2_valid_q;
  assign out_result    = s2_q.result;
  assign out_rd        = s2_q.rd;
  assign out_wb_en     = s2_q.wb_en;
  assign out_br_taken  = s2_q.br_taken;
  assign out_br_target = s2_q.br_target;
  assign out_illegal   = s2_q.illegal;

endmodule
